// File: rtl/switch_bank_reader.sv
// Synchronised, debounced switch bank with sticky change flags, read as four CPU registers (SWITCH_DEBOUNCE_EN builds the debouncer).
// Latency: 2-flop sync, then DEBOUNCE_CYCLES+1 edges of agreement (or none without debounce); read data registered on the sampling edge.
// No backpressure: one independent read per cycle, read data holds when not selected.
module switch_bank_reader #(
    parameter int SW_WIDTH        = 24,
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  switch_ctrl,
    input  logic                  io_read,
    input  logic [1:0]            addr,
    input  logic [SW_WIDTH-1:0]   switches,
    output logic [DATA_WIDTH-1:0] input_data
);
    localparam int HI_WIDTH = SW_WIDTH - DATA_WIDTH;

    logic [SW_WIDTH-1:0]   sync1;
    logic [SW_WIDTH-1:0]   sync2;
    logic [SW_WIDTH-1:0]   stable;
    logic [SW_WIDTH-1:0]   stable_next;
    logic [DATA_WIDTH-1:0] flags;
    logic [DATA_WIDTH-1:0] flags_next;
    logic [DATA_WIDTH-1:0] read_mux;
    logic                  busy;
    logic                  read_en;
    logic                  flag_clear;

`ifdef SWITCH_DEBOUNCE_EN
    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0]  candidate;
    logic [SW_WIDTH-1:0]  candidate_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 busy_next;

    always_comb begin
        candidate_next = candidate;
        cnt_next       = cnt;
        busy_next      = busy;
        stable_next    = stable;
        if (sync2 != candidate) begin
            candidate_next = sync2;
            cnt_next       = '0;
            busy_next      = 1'b1;
        end else if (busy && (cnt == CNT_LAST)) begin
            stable_next = candidate;
            busy_next   = 1'b0;
        end else if (busy) begin
            cnt_next = cnt + CNT_WIDTH'(1);
        end
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            candidate <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
        end else begin
            candidate <= candidate_next;
            cnt       <= cnt_next;
            busy      <= busy_next;
        end
    end
`else
    assign busy        = 1'b0;
    assign stable_next = sync2;
`endif

    assign read_en    = switch_ctrl && io_read;
    assign flag_clear = read_en && (addr == 2'd2);

    // A flag raised on this edge survives a clearing read on the same edge.
    assign flags_next = (flag_clear ? '0 : flags)
                      | (stable_next[DATA_WIDTH-1:0] ^ stable[DATA_WIDTH-1:0]);

    // Image reads see the value accepted on this edge; flags/status report pre-edge state.
    always_comb begin
        read_mux = '0;
        case (addr)
            2'd0:    read_mux = stable_next[DATA_WIDTH-1:0];
            2'd1:    read_mux[HI_WIDTH-1:0] = stable_next[SW_WIDTH-1:DATA_WIDTH];
            2'd2:    read_mux = flags;
            default: begin
                read_mux[0] = busy;
                read_mux[1] = |flags;
            end
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            flags      <= '0;
            input_data <= '0;
        end else begin
            sync1  <= switches;
            sync2  <= sync1;
            stable <= stable_next;
            flags  <= flags_next;
            if (read_en) begin
                input_data <= read_mux;
            end
        end
    end
endmodule

// File: tb/tb_switch_bank_reader.sv
// Directed and randomized checks of switch_bank_reader against a sample-history reference model.
module tb_switch_bank_reader;
    localparam int SW = 24;
    localparam int DW = 16;
    localparam int D  = 4;
`ifdef SWITCH_DEBOUNCE_EN
    localparam int LAT = D + 3;
`else
    localparam int LAT = 3;
`endif

    logic          clock;
    logic          reset;
    logic          switch_ctrl;
    logic          io_read;
    logic [1:0]    addr;
    logic [SW-1:0] switches;
    logic [DW-1:0] input_data;

    switch_bank_reader #(
        .SW_WIDTH(SW), .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clock(clock), .reset(reset), .switch_ctrl(switch_ctrl), .io_read(io_read),
        .addr(addr), .switches(switches), .input_data(input_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: raw samples taken at each negedge, newest at index 0.
    logic [SW-1:0] hist [0:D+2];
    logic [SW-1:0] m_stable;
    logic [DW-1:0] m_flags;
    logic          m_busy;
    logic [DW-1:0] m_data;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i <= D + 2; i++) hist[i] = '0;
        m_stable = '0;
        m_flags  = '0;
        m_busy   = 1'b0;
        m_data   = '0;
    endtask

    task automatic do_reset(input logic [SW-1:0] sw_during, input logic [SW-1:0] sw_after);
        @(posedge clock);
        #1;
        reset = 1'b1;
        switches = sw_during;
        switch_ctrl = 1'b0;
        io_read = 1'b0;
        #2;
        chk("reset_async", input_data, '0);
        repeat (3) @(negedge clock);
        #1;
        chk("reset_hold", input_data, '0);
        model_reset();
        reset = 1'b0;
        switches = sw_after;
    endtask

    // One clock: drive after posedge, update model at negedge, compare just after.
    task automatic cyc(input logic [SW-1:0] sw, input logic sel, input logic rd, input logic [1:0] a);
        logic [SW-1:0] stab_a;
        logic          busy_a;
        logic [DW-1:0] rdv;
        int            run;
        @(posedge clock);
        #1;
        switches = sw;
        switch_ctrl = sel;
        io_read = rd;
        addr = a;
        @(negedge clock);
        for (int i = D + 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = sw;
`ifdef SWITCH_DEBOUNCE_EN
        // Accept once the synchronised value has been seen on D+1 consecutive edges.
        run = 1;
        for (int i = 3; i <= D + 2; i++)
            if (run == i - 2 && hist[i] == hist[2]) run++;
        busy_a = (run < D + 1);
        stab_a = busy_a ? m_stable : hist[2];
`else
        run = 0;
        busy_a = 1'b0;
        stab_a = hist[2];
`endif
        if (sel && rd) begin
            rdv = '0;
            case (a)
                2'd0: rdv = stab_a[DW-1:0];
                2'd1: rdv[SW-DW-1:0] = stab_a[SW-1:DW];
                2'd2: rdv = m_flags;
                default: begin
                    rdv[0] = m_busy;
                    rdv[1] = |m_flags;
                end
            endcase
            m_data = rdv;
        end
        m_flags = ((sel && rd && a == 2'd2) ? '0 : m_flags) | (stab_a[DW-1:0] ^ m_stable[DW-1:0]);
        m_stable = stab_a;
        m_busy = busy_a;
        #1;
        chk("cycle", input_data, m_data);
    endtask

    task automatic rd(input logic [SW-1:0] sw, input logic [1:0] a);
        cyc(sw, 1'b1, 1'b1, a);
    endtask

    task automatic idle(input logic [SW-1:0] sw, input int n);
        for (int i = 0; i < n; i++) cyc(sw, 1'b0, 1'b0, 2'd0);
    endtask

    initial begin
        logic [SW-1:0] cur;
        int hold;
        reset = 1'b1;
        switch_ctrl = 1'b0;
        io_read = 1'b0;
        addr = 2'd0;
        switches = 24'hFFFFFF;
        model_reset();

        do_reset(24'hFFFFFF, 24'h000000);
        rd(24'h000000, 2'd0);
        chk("read_after_reset", input_data, 16'h0000);
        idle(24'h000000, 6);

        // Clean step: first sampled on cycle 1, accepted on cycle LAT.
        cyc(24'hA51234, 1'b0, 1'b0, 2'd0);
        for (int i = 2; i <= LAT - 2; i++) cyc(24'hA51234, 1'b0, 1'b0, 2'd0);
        rd(24'hA51234, 2'd0);
        chk("step_before", input_data, 16'h0000);
        rd(24'hA51234, 2'd0);
        chk("step_at_latency", input_data, 16'h1234);
        rd(24'hA51234, 2'd1);
        chk("step_high", input_data, 16'h00A5);
        rd(24'hA51234, 2'd2);
        chk("flags_first", input_data, 16'h1234);
        rd(24'hA51234, 2'd2);
        chk("flags_cleared", input_data, 16'h0000);

        // Two-cycle glitch on bit 0.
        idle(24'hA51235, 2);
        idle(24'hA51234, 1);
        rd(24'hA51234, 2'd3);
`ifdef SWITCH_DEBOUNCE_EN
        chk("glitch_busy", input_data, 16'h0001);
`else
        chk("glitch_status", input_data, 16'h0002);
`endif
        idle(24'hA51234, 8);
        rd(24'hA51234, 2'd0);
        chk("glitch_stable", input_data, 16'h1234);
        rd(24'hA51234, 2'd2);
`ifdef SWITCH_DEBOUNCE_EN
        chk("glitch_flags", input_data, 16'h0000);
`else
        chk("glitch_flags", input_data, 16'h0001);
`endif

        // Clear/set collision: bit 3 accepted on the same edge as a flag read.
        idle(24'hA51334, 11);
        cyc(24'hA5133C, 1'b0, 1'b0, 2'd0);
        for (int i = 2; i <= LAT - 1; i++) cyc(24'hA5133C, 1'b0, 1'b0, 2'd0);
        rd(24'hA5133C, 2'd2);
        chk("collide_old", input_data, 16'h0100);
        rd(24'hA5133C, 2'd2);
        chk("collide_new", input_data, 16'h0008);
        rd(24'hA5133C, 2'd3);
        chk("status_quiet", input_data, 16'h0000);

        // Randomized holds, single-bit flips and mixed reads.
        cur = 24'hA5133C;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1) cur = SW'($urandom);
            else cur = cur ^ (SW'(1) << $urandom_range(0, SW - 1));
            hold = $urandom_range(1, D + 4);
            for (int j = 0; j < hold; j++)
                cyc(cur, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end

        // Reset with a change still pending: it must never surface.
        do_reset(24'hFFFFFF, 24'h000000);
        idle(24'h00F00F, 2);
        do_reset(24'h00F00F, 24'h000000);
        idle(24'h000000, LAT + 3);
        rd(24'h000000, 2'd0);
        chk("pending_discarded", input_data, 16'h0000);
        rd(24'h000000, 2'd2);
        chk("pending_flags", input_data, 16'h0000);
        rd(24'h000000, 2'd3);
        chk("pending_status", input_data, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/switch_bank_reader.md
# switch_bank_reader

Parametrised memory-mapped switch input port for the CPU I/O subsystem. It synchronises and debounces a wide bank of board switches, holds a stable image and sticky per-bit change flags, and returns one of four registers to the CPU on an I/O read. It sits between the board switch pins and the memory/IO read mux. It replaces single-halfword switch capture with multi-register access and change detection.

## Interface
Parameters:
- SW_WIDTH, 24, number of physical switch inputs; DATA_WIDTH < SW_WIDTH <= 2*DATA_WIDTH
- DATA_WIDTH, 16, width of the CPU read data
- DEBOUNCE_CYCLES, 4, clock cycles the synchronised input must be unchanged before acceptance; >= 1

Ports:
- clock  in  1  system clock; all registers update on the falling edge
- reset  in  1  reset, asynchronous, active-high
- switch_ctrl  in  1  address decode select for this block
- io_read  in  1  CPU I/O read strobe
- addr  in  2  register select: 0 = stable[DATA_WIDTH-1:0], 1 = stable[SW_WIDTH-1:DATA_WIDTH] zero-extended, 2 = change flags, 3 = status
- switches  in  SW_WIDTH  raw asynchronous switch pins
- input_data  out  DATA_WIDTH  registered read data

## Operation
- Two-flop synchroniser: sync1 <= switches, sync2 <= sync1.
- Debounce (per edge, bank-wide):
  - sync2 != candidate: candidate <= sync2, cnt <= 0, busy <= 1.
  - Otherwise, if busy and cnt == DEBOUNCE_CYCLES-1: stable <= candidate, busy <= 0, flags[i] set for every i < DATA_WIDTH where candidate[i] != stable[i].
  - Otherwise, if busy: cnt <= cnt+1.
  - Idle (busy=0): the counter holds.
- cnt width is $clog2(DEBOUNCE_CYCLES+1).
- Read: when switch_ctrl && io_read, input_data <= the register selected by addr; otherwise input_data holds.
- Status register: bit0 = busy, bit1 = |flags, remaining bits 0.
- Read-to-clear: reading addr 2 clears flags in the same edge that captures them.
- Set wins: a flag set by a stable update in the same edge as a clearing read stays set, and the read returns the pre-update flags.
- Reset mid-debounce: all state returns to reset values, and the pending candidate is discarded.

## Timing
- Reset values:
  - sync1, sync2, candidate, stable: all 0.
  - cnt, busy, flags: 0.
  - input_data: 0.
- Read latency: data is valid from the negedge on which switch_ctrl && io_read is sampled, so the CPU consumes it on the following posedge.
- Input latency: a clean step first sampled at negedge 1 appears in stable at negedge DEBOUNCE_CYCLES+3, with flags set on the same edge.
- Glitch rejection: a pulse shorter than DEBOUNCE_CYCLES cycles restarts the counter and never reaches stable. If the input returns to the old value, flags are not set.
- Back-to-back reads: each read is independent; one read per cycle is supported.

## Configuration
- SWITCH_DEBOUNCE_EN defined: the debounce counter and candidate logic are built as described above.
- SWITCH_DEBOUNCE_EN undefined:
  - stable <= sync2 every edge, so input latency is exactly 3 negedges.
  - Flags are set on any bit change between sync2 and stable.
  - busy is constant 0, and cnt and candidate are removed.

## Test plan
- Reset while switches=24'hFFFFFF → input_data=0. Read addr 0 immediately after reset release → 16'h0000.
- Debounce (DEBOUNCE_CYCLES=4): set switches=24'hA5_1234. Read addr 0 at negedge 6 → 16'h0000. Read addr 0 at negedge 7 → 16'h1234. Read addr 1 → 16'h00A5.
- Glitch: bit0 high for 2 cycles, then low → stable unchanged, flags=0, and busy seen as 1 by an addr 3 read during the glitch.
- Flags: after stable changes 0→16'h1234, read addr 2 → 16'h1234. A second read of addr 2 → 16'h0000.
- Clear/set collision: a stable update on bit3 in the same edge as an addr 2 read → that read returns the old flags, and the next read returns 16'h0008.
- Macro off: a step on switches appears in addr 0 at negedge 3, and an addr 3 read → 0.
